fir_filter_nch_array: RTL and testbench

- Parametrised N-lane FIR array; the successor to the fixed 16-lane filter top.
- All lanes share one coefficient set and one valid/ready handshake; data per lane is independent.
- Adds double-buffered coefficient loading, output backpressure, rounding/saturation and a drain-before-swap FSM.
- Sits between the DMAC read path (upstream) and the result writer (downstream).

---
 rtl/fir_array_pkg.sv | 40 ++++
 rtl/fir_lane.sv | 105 ++++++++++
 rtl/fir_filter_nch_array.sv | 149 ++++++++++++++
 tb/tb_fir_filter_nch_array.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_array_pkg.sv
// fir_array_pkg: shared types and arithmetic helpers for the N-lane FIR array.
//   cfg_state_e : coefficient/configuration FSM state (CFG=0, RUN=1, DRAIN=2).
//   acc_width   : accumulator width for a given sample/coef width and tap count.
//   round_shift : round-half-up then arithmetic right shift.
//   saturate    : clamp to a dw-bit signed range.
// Helpers work on 64-bit signed values; the lane sign-extends into them.
package fir_array_pkg;

    typedef enum logic [1:0] {
        StCfg   = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } cfg_state_e;

    // Holds the sum of TAPS full-scale products without overflow.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw,
                                              input int unsigned taps);
        return dw + cw + $clog2(taps);
    endfunction

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc,
                                                        input int unsigned shift);
        return (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                     input int unsigned dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/fir_lane.sv
// fir_lane: one data lane of the FIR array.
//   Delay line (tap 0 newest), registered products, registered accumulator and a
//   rounded/saturated output register. All enables come from the top.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clr_i          clear the delay line (coefficient swap)
//   acc_en_i       shift in sample_i and register products
//   s2_en_i        register the product sum
//   out_en_i       register the rounded/saturated result
//   coef_i         active coefficients, tap i at [i*CW +: CW]
//   sample_i       input sample, sample_o filtered output
//   sat_o          (FIR_SAT_STATUS_EN only) current output was clamped
module fir_lane
    import fir_array_pkg::*;
#(
    parameter int unsigned DW        = 24,
    parameter int unsigned CW        = 16,
    parameter int unsigned TAPS      = 8,
    parameter int unsigned OUT_SHIFT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               acc_en_i,
    input  logic               s2_en_i,
    input  logic               out_en_i,
    input  logic [TAPS*CW-1:0] coef_i,
    input  logic [DW-1:0]      sample_i,
`ifdef FIR_SAT_STATUS_EN
    output logic               sat_o,
`endif
    output logic [DW-1:0]      sample_o
);

    localparam int unsigned PW = DW + CW;
    localparam int unsigned AW = acc_width(DW, CW, TAPS);

    logic signed [DW-1:0] dly_q  [TAPS];
    logic signed [DW-1:0] dly_d  [TAPS];
    logic signed [PW-1:0] prod_q [TAPS];
    logic signed [PW-1:0] prod_d [TAPS];
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] out_q, out_d;
    logic signed [63:0]   rnd;
    logic signed [63:0]   sat_val;

    always_comb begin
        dly_d  = dly_q;
        prod_d = prod_q;
        acc_d  = acc_q;
        out_d  = out_q;
        if (clr_i) begin
            for (int i = 0; i < TAPS; i++) dly_d[i] = '0;
        end else if (acc_en_i) begin
            dly_d[0] = $signed(sample_i);
            for (int i = 1; i < TAPS; i++) dly_d[i] = dly_q[i-1];
            // Products use the delay line including the sample being accepted.
            for (int i = 0; i < TAPS; i++) begin
                prod_d[i] = PW'(dly_d[i]) * PW'($signed(coef_i[i*CW +: CW]));
            end
        end
        if (s2_en_i) begin
            acc_d = '0;
            for (int i = 0; i < TAPS; i++) acc_d = acc_d + AW'(prod_q[i]);
        end
        rnd     = round_shift(64'(acc_q), OUT_SHIFT);
        sat_val = saturate(rnd, DW);
        if (out_en_i) out_d = DW'(sat_val);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TAPS; i++) begin
                dly_q[i]  <= '0;
                prod_q[i] <= '0;
            end
            acc_q <= '0;
            out_q <= '0;
        end else begin
            dly_q  <= dly_d;
            prod_q <= prod_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
        end
    end

    assign sample_o = out_q;

`ifdef FIR_SAT_STATUS_EN
    logic sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        if (out_en_i) sat_d = (sat_val != rnd);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) sat_q <= 1'b0;
        else       sat_q <= sat_d;
    end

    assign sat_o = sat_q;
`endif

endmodule

// File: rtl/fir_filter_nch_array.sv
// fir_filter_nch_array: LANES-wide FIR array sharing one coefficient set and handshake.
//   Shadow/active coefficient banks, drain-before-swap FSM, 3-stage valid pipeline
//   (products, sum, rounded/saturated output) with output backpressure.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   coef_we/coef_addr/coef_wdata  shadow coefficient write (any state)
//   coef_commit                   request shadow->active swap
//   in_valid/in_ready/in_data     input vector, lane k at [k*DW +: DW]
//   out_valid/out_ready/out_data  output vector, same packing
//   cfg_state                     FSM state (CFG=0, RUN=1, DRAIN=2)
//   sat_flag                      sticky per-lane saturation, only when FIR_SAT_STATUS_EN
//                                 is defined; cleared on reset and on every swap
module fir_filter_nch_array
    import fir_array_pkg::*;
#(
    parameter int unsigned LANES     = 16,
    parameter int unsigned DW        = 24,
    parameter int unsigned CW        = 16,
    parameter int unsigned TAPS      = 8,
    parameter int unsigned OUT_SHIFT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [CW-1:0]            coef_wdata,
    input  logic                     coef_commit,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DW-1:0]      in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*DW-1:0]      out_data,
`ifdef FIR_SAT_STATUS_EN
    output logic [LANES-1:0]         sat_flag,
`endif
    output logic [1:0]               cfg_state
);

    cfg_state_e         state_q, state_d;
    logic [TAPS*CW-1:0] shadow_q, shadow_d;
    logic [TAPS*CW-1:0] active_q, active_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s2_valid_q, s2_valid_d;
    logic               out_valid_q, out_valid_d;
    logic               adv;
    logic               accept;
    logic               swap;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = (state_q == StRun) && adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        swap        = 1'b0;
        s1_valid_d  = s1_valid_q;
        s2_valid_d  = s2_valid_q;
        out_valid_d = out_valid_q;

        // Write lands before any copy so a same-cycle commit picks it up.
        if (coef_we) shadow_d[int'(coef_addr)*CW +: CW] = coef_wdata;

        case (state_q)
            StCfg:   if (coef_commit) swap = 1'b1;
            StRun:   if (coef_commit) state_d = StDrain;
            StDrain: if (!s1_valid_q && !s2_valid_q && !out_valid_q) swap = 1'b1;
            default: state_d = StCfg;
        endcase

        if (swap) begin
            active_d = shadow_d;
            state_d  = StRun;
        end

        if (adv) begin
            s1_valid_d  = accept;
            s2_valid_d  = s1_valid_q;
            out_valid_d = s2_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StCfg;
            shadow_q    <= '0;
            active_q    <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign cfg_state = state_q;

`ifdef FIR_SAT_STATUS_EN
    logic [LANES-1:0] lane_sat;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fir_lane #(
            .DW        (DW),
            .CW        (CW),
            .TAPS      (TAPS),
            .OUT_SHIFT (OUT_SHIFT)
        ) u_lane (
            .clk_i    (clk),
            .rst_i    (rst),
            .clr_i    (swap),
            .acc_en_i (accept),
            .s2_en_i  (adv && s1_valid_q),
            .out_en_i (adv && s2_valid_q),
            .coef_i   (active_q),
            .sample_i (in_data[k*DW +: DW]),
`ifdef FIR_SAT_STATUS_EN
            .sat_o    (lane_sat[k]),
`endif
            .sample_o (out_data[k*DW +: DW])
        );
    end

`ifdef FIR_SAT_STATUS_EN
    logic [LANES-1:0] sat_flag_q, sat_flag_d;

    always_comb begin
        sat_flag_d = sat_flag_q;
        if (swap) sat_flag_d = '0;
        else if (out_valid_q && out_ready) sat_flag_d = sat_flag_q | lane_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) sat_flag_q <= '0;
        else     sat_flag_q <= sat_flag_d;
    end

    assign sat_flag = sat_flag_q;
`endif

endmodule

// File: tb/tb_fir_filter_nch_array.sv
// Testbench for fir_filter_nch_array: directed steps with a scoreboard fed by a
// behavioural model at every accepted input and drained at every emitted output.
module tb_fir_filter_nch_array;

    localparam int unsigned LANES     = 16;
    localparam int unsigned DW        = 24;
    localparam int unsigned CW        = 16;
    localparam int unsigned TAPS      = 8;
    localparam int unsigned OUT_SHIFT = 15;
    localparam int unsigned VW        = LANES * DW;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          coef_we     = 1'b0;
    logic [2:0]    coef_addr   = '0;
    logic [CW-1:0] coef_wdata  = '0;
    logic          coef_commit = 1'b0;
    logic          in_valid    = 1'b0;
    logic [VW-1:0] in_data     = '0;
    logic          out_ready   = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [VW-1:0] out_data;
    logic [1:0]    cfg_state;
`ifdef FIR_SAT_STATUS_EN
    logic [LANES-1:0] sat_flag;
`endif

    int checks   = 0;
    int failures = 0;

    logic [VW-1:0] sb[$];
    longint        dl_m     [LANES][TAPS];
    longint        shadow_m [TAPS];
    longint        active_m [TAPS];
    bit            pending  = 1'b0;
    bit            last_acc = 1'b0;

    fir_filter_nch_array #(
        .LANES     (LANES),
        .DW        (DW),
        .CW        (CW),
        .TAPS      (TAPS),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
`ifdef FIR_SAT_STATUS_EN
        .sat_flag    (sat_flag),
`endif
        .cfg_state   (cfg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            shadow_m[i] = 0;
            active_m[i] = 0;
            for (int k = 0; k < LANES; k++) dl_m[k][i] = 0;
        end
        pending = 1'b0;
        sb.delete();
    endtask

    task automatic model_accept();
        logic [VW-1:0] e;
        longint        acc;
        longint        rnd;
        longint        hi;
        // No accept can occur between a commit and the real swap, so applying it here is exact.
        if (pending) begin
            active_m = shadow_m;
            for (int k = 0; k < LANES; k++)
                for (int i = 0; i < TAPS; i++) dl_m[k][i] = 0;
            pending = 1'b0;
        end
        hi = (longint'(1) <<< (DW - 1)) - 1;
        e  = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int i = TAPS - 1; i > 0; i--) dl_m[k][i] = dl_m[k][i-1];
            dl_m[k][0] = longint'($signed(in_data[k*DW +: DW]));
            acc = 0;
            for (int i = 0; i < TAPS; i++) acc = acc + dl_m[k][i] * active_m[i];
            rnd = (acc + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
            if (rnd > hi) rnd = hi;
            else if (rnd < -hi - 1) rnd = -hi - 1;
            e[k*DW +: DW] = rnd[DW-1:0];
        end
        sb.push_back(e);
    endtask

    // Called at a negedge with inputs driven; observes the handshake and advances one clock.
    task automatic cycle();
        #1;
        last_acc = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_output", VW'(out_valid), '0);
                else chk("out_vec", out_data, sb.pop_front());
            end
            if (coef_we) shadow_m[coef_addr] = longint'($signed(coef_wdata));
            if (in_valid && in_ready) begin
                model_accept();
                last_acc = 1'b1;
            end
            if (coef_commit) pending = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_coef(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = a[2:0];
        coef_wdata = v[CW-1:0];
        cycle();
        coef_we    = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        cycle();
        coef_commit = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < LANES; k++) in_data[k*DW +: DW] = v[DW-1:0];
    endtask

    task automatic set_lane0(input int v);
        in_data = '0;
        in_data[DW-1:0] = v[DW-1:0];
    endtask

    task automatic set_ramp(input int j, input int base);
        int v;
        for (int k = 0; k < LANES; k++) begin
            v = j * (k + 1) * base * ((k % 2 == 1) ? -1 : 1);
            in_data[k*DW +: DW] = v[DW-1:0];
        end
    endtask

    // mode 0: all lanes = val; 1: ramp scaled by val; 2: val on lane 0 for the first vector only.
    task automatic stream(input int n, input int mode, input int val, input int stall_at);
        int sent    = 0;
        bit stalled = 1'b0;
        in_valid = 1'b1;
        for (int b = 0; b < 300 && sent < n; b++) begin
            if (sent == stall_at && !stalled) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    chk("stall_in_ready", VW'(in_ready), '0);
                    if (sb.size() == 0) chk("stall_sb_nonempty", VW'(sb.size()), VW'(1));
                    else chk("stall_hold", out_data, sb[0]);
                    cycle();
                end
                out_ready = 1'b1;
            end
            case (mode)
                0:       set_all(val);
                1:       set_ramp(sent + 1, val);
                default: set_lane0((sent == 0) ? val : 0);
            endcase
            cycle();
            if (last_acc) sent++;
        end
        in_valid = 1'b0;
        chk("stream_sent", VW'(sent), VW'(n));
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int b = 0; b < 40 && sb.size() != 0; b++) cycle();
        chk("drain_empty", VW'(sb.size()), '0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", VW'(in_ready), '0);
        chk("rst_out_valid", VW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_cfg_state", VW'(cfg_state), '0);

        // Inputs offered before any commit are refused.
        in_valid = 1'b1;
        set_all(5);
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("precfg_in_ready", VW'(in_ready), '0);
            chk("precfg_out_valid", VW'(out_valid), '0);
            cycle();
        end
        in_valid = 1'b0;

        // Impulse with c[k] = (k+1)*4096: lane 0 yields 1..8 then 0.
        for (int i = 0; i < TAPS; i++) wr_coef(i, (i + 1) * 4096);
        commit();
        #1;
        chk("commit_run", VW'(cfg_state), VW'(1));
        set_lane0(8);
        in_valid = 1'b1;
        cycle();
        chk("impulse_acc", VW'(last_acc), VW'(1));
        set_lane0(0);
        #1;
        chk("lat_t0", VW'(out_valid), '0);
        cycle();
        #1;
        chk("lat_t1", VW'(out_valid), '0);
        cycle();
        #1;
        chk("lat_t2", VW'(out_valid), VW'(1));
        stream(7, 0, 0, -1);
        drain();
        chk("impulse_tail", VW'(out_data[DW-1:0]), '0);

        // Saturation, both rails.
        for (int i = 0; i < TAPS; i++) wr_coef(i, 32767);
        commit();
        #1;
        chk("commit_drain", VW'(cfg_state), VW'(2));
        stream(12, 0, 8388607, -1);
        drain();
        chk("sat_pos", VW'(out_data[DW-1:0]), VW'(24'h7FFFFF));
        stream(12, 0, -8388608, -1);
        drain();
        chk("sat_neg", VW'(out_data[DW-1:0]), VW'(24'h800000));
`ifdef FIR_SAT_STATUS_EN
        chk("sat_flag", VW'(sat_flag), VW'({LANES{1'b1}}));
`endif

        // Ramp 1..20 with a 5-cycle output stall after 8 accepts.
        for (int i = 0; i < TAPS; i++) wr_coef(i, 1234 * (i + 1) * ((i % 2 == 1) ? -1 : 1));
        commit();
        stream(20, 1, 1000, 8);
        drain();

        // Commit with two vectors in flight; tap 0 written in the commit cycle.
        for (int i = 0; i < TAPS; i++) wr_coef(i, 4096 * (8 - i));
        in_valid = 1'b1;
        set_ramp(3, 700);
        cycle();
        chk("mid_acc_a", VW'(last_acc), VW'(1));
        set_ramp(5, 700);
        coef_commit = 1'b1;
        coef_we     = 1'b1;
        coef_addr   = 3'd0;
        coef_wdata  = 16'd3000;
        cycle();
        chk("mid_acc_b", VW'(last_acc), VW'(1));
        coef_commit = 1'b0;
        coef_we     = 1'b0;
        set_lane0(8);
        #1;
        chk("mid_drain_state", VW'(cfg_state), VW'(2));
        chk("mid_drain_in_ready", VW'(in_ready), '0);
        begin
            int b = 0;
            do begin
                cycle();
                b++;
            end while (!last_acc && b < 20);
        end
        chk("mid_resume", VW'(last_acc), VW'(1));
        stream(8, 0, 0, -1);
        drain();

        // Reset with the pipeline full and stalled.
        out_ready = 1'b0;
        stream(3, 0, 1234, -1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("rrst_out_valid", VW'(out_valid), '0);
        chk("rrst_out_data", out_data, '0);
        chk("rrst_cfg_state", VW'(cfg_state), '0);
        out_ready = 1'b1;
        commit();
        stream(9, 2, 8, -1);
        drain();
        chk("rrst_zero_coef", VW'(out_data[DW-1:0]), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
